// File: rtl/hart_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hart_mem_pkg
// Purpose  : Shared types and defaults for the hart memory-port arbiter.
//            owner_t     - which requester owns the outstanding transaction
//            arb_state_t - arbiter state (idle / waiting on memory latency)
// Revision : 1.0 - initial release
// ============================================================================
package hart_mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic {
    OWNER_IF   = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

endpackage : hart_mem_pkg
`default_nettype wire

// File: rtl/hart_mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : hart_mem_arb_pick
// Purpose  : Combinational winner selection between fetch and data requests.
//            Optional macro HART_ARB_ROUND_ROBIN_EN selects round-robin on
//            conflict (the requester that did not win last time wins);
//            otherwise data has fixed priority over fetch.
// Ports    : if_req, d_req  - pending requests
//            issue_ok       - the arbiter may start a transaction this cycle
//            last_winner    - previous winner (used only in round-robin mode)
//            grant_if/grant_d - one-hot (or zero) grant
// Revision : 1.0 - initial release
// ============================================================================
module hart_mem_arb_pick
  import hart_mem_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic issue_ok,
  input  logic last_winner,
  output logic grant_if,
  output logic grant_d
);

`ifdef HART_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (issue_ok) begin
      if (if_req && d_req) begin
        // Conflict: hand the port to whoever did not win last time.
        if (last_winner == OWNER_DATA) grant_if = 1'b1;
        else                           grant_d  = 1'b1;
      end else begin
        grant_if = if_req;
        grant_d  = d_req;
      end
    end
  end
`else
  // Fixed priority: data always beats fetch; last_winner is not consulted.
  logic unused_last_winner;
  assign unused_last_winner = last_winner;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (issue_ok) begin
      grant_d  = d_req;
      grant_if = if_req && !d_req;
    end
  end
`endif

endmodule : hart_mem_arb_pick
`default_nettype wire

// File: rtl/hart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hart_mem_arbiter
// Purpose  : Shares the hart's single memory port between instruction fetch
//            and load/store. One transaction outstanding, fixed read latency
//            MEM_LATENCY (1..4). Grants and the memory strobe are issued
//            combinationally; the response is routed back to the owner.
//            Optional macro HART_ARB_ROUND_ROBIN_EN enables round-robin
//            arbitration on conflict (default: data has fixed priority).
// Ports    : clk, reset (sync, active-high)
//            if_req/if_addr -> if_gnt, if_rvalid/if_rdata   fetch side
//            d_req/d_we/d_addr/d_wdata/d_wmask -> d_gnt, d_rvalid/d_rdata
//            mem_en/mem_we/mem_addr/mem_wdata/mem_wmask <- mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module hart_mem_arbiter
  import hart_mem_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);

  arb_state_t state, state_nxt;
  owner_t     owner, owner_nxt;
  logic       owner_we, owner_we_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;

  logic resp_cycle;
  logic issue_ok;
  logic grant_if;
  logic grant_d;
  owner_t last_winner;

  // lat_cnt==1 in WAIT is the response cycle, which doubles as an issue slot
  // so that back-to-back transactions sustain one per MEM_LATENCY cycles.
  // Everything is masked while reset is high so outputs read zero.
  assign resp_cycle = (state == ST_WAIT) && (lat_cnt == 3'd1) && !reset;
  assign issue_ok   = !reset && ((state == ST_IDLE) || resp_cycle);

  hart_mem_arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .issue_ok    (issue_ok),
    .last_winner (last_winner),
    .grant_if    (grant_if),
    .grant_d     (grant_d)
  );

`ifdef HART_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)         last_winner <= OWNER_DATA;
    else if (grant_d)  last_winner <= OWNER_DATA;
    else if (grant_if) last_winner <= OWNER_IF;
  end
`else
  assign last_winner = OWNER_DATA;
`endif

  // Grant and memory request side.
  assign if_gnt = grant_if;
  assign d_gnt  = grant_d;
  assign mem_en = grant_if || grant_d;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (grant_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wmask = d_wmask;
    end else if (grant_if) begin
      mem_addr  = if_addr;
    end
  end

  // Response side: route to the owner; stores return a zero data ack.
  assign if_rvalid = resp_cycle && (owner == OWNER_IF);
  assign d_rvalid  = resp_cycle && (owner == OWNER_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !owner_we) ? mem_rdata : '0;

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    owner_we_nxt = owner_we;
    lat_cnt_nxt  = lat_cnt;
    if (mem_en) begin
      state_nxt    = ST_WAIT;
      owner_nxt    = grant_d ? OWNER_DATA : OWNER_IF;
      owner_we_nxt = grant_d && d_we;
      lat_cnt_nxt  = LAT_INIT;
    end else if (state == ST_WAIT) begin
      if (lat_cnt == 3'd1) begin
        state_nxt   = ST_IDLE;
        lat_cnt_nxt = 3'd0;
      end else begin
        lat_cnt_nxt = lat_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= OWNER_IF;
      owner_we <= 1'b0;
      lat_cnt  <= 3'd0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      owner_we <= owner_we_nxt;
      lat_cnt  <= lat_cnt_nxt;
    end
  end

endmodule : hart_mem_arbiter
`default_nettype wire

// File: tb/tb_hart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hart_mem_arbiter
// Purpose  : Directed self-checking bench. Three arbiter instances share the
//            stimulus with MEM_LATENCY = 1, 2 and 3; each scenario checks the
//            instance whose latency it targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hart_mem_arbiter;

`ifdef HART_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam bit D_FIRST = !RR;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] mem_rdata;

  logic [3:1]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata [1:3];
  logic [31:0] d_rdata  [1:3];
  logic [31:0] mem_addr [1:3];
  logic [31:0] mem_wdata[1:3];
  logic [3:0]  mem_wmask[1:3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 1; k <= 3; k++) begin : g_dut
    hart_mem_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LATENCY(k)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt[k]),
      .if_rvalid (if_rvalid[k]),
      .if_rdata  (if_rdata[k]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wmask   (d_wmask),
      .d_gnt     (d_gnt[k]),
      .d_rvalid  (d_rvalid[k]),
      .d_rdata   (d_rdata[k]),
      .mem_en    (mem_en[k]),
      .mem_we    (mem_we[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_wmask (mem_wmask[k]),
      .mem_rdata (mem_rdata)
    );
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset  = 1'b1;
    next_cycle();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = 32'h0050_0093;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1], mem_en[1], mem_we[1]} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1], mem_en[1], mem_we[1]});
    end
    checks++;
    if ({mem_addr[1], if_rdata[1]} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {mem_addr[1], if_rdata[1]});
    end
  endtask

  // Continues from test_reset: the fetch held through reset issues first.
  task automatic test_fetch();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt[1], d_gnt[1], mem_en[1], mem_we[1], mem_wmask[1]} !== 8'b1010_0000) begin
      failures++;
      $display("FAIL fetch_gnt got=%b exp=10100000",
               {if_gnt[1], d_gnt[1], mem_en[1], mem_we[1], mem_wmask[1]});
    end
    checks++;
    if (mem_addr[1] !== 32'h10) begin
      failures++;
      $display("FAIL fetch_addr got=%h exp=00000010", mem_addr[1]);
    end
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid[1], d_rvalid[1], mem_en[1]} !== 3'b100) begin
      failures++;
      $display("FAIL fetch_rvalid got=%b exp=100", {if_rvalid[1], d_rvalid[1], mem_en[1]});
    end
    checks++;
    if (if_rdata[1] !== 32'h0050_0093) begin
      failures++;
      $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata[1]);
    end
  endtask

  task automatic test_contest();
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    checks++;
    if ({if_gnt[1], d_gnt[1]} !== (D_FIRST ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL contest_first_gnt got=%b exp=%b", {if_gnt[1], d_gnt[1]}, D_FIRST ? 2'b01 : 2'b10);
    end
    checks++;
    if (mem_addr[1] !== (D_FIRST ? 32'h200 : 32'h20)) begin
      failures++;
      $display("FAIL contest_first_addr got=%h", mem_addr[1]);
    end
    next_cycle();
    if (D_FIRST) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1]} !== (D_FIRST ? 4'b1001 : 4'b0110)) begin
      failures++;
      $display("FAIL contest_second got=%b exp=%b", {if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1]},
               D_FIRST ? 4'b1001 : 4'b0110);
    end
    checks++;
    if ((D_FIRST ? d_rdata[1] : if_rdata[1]) !== 32'h1111_2222) begin
      failures++;
      $display("FAIL contest_first_rdata got=%h exp=11112222", D_FIRST ? d_rdata[1] : if_rdata[1]);
    end
    checks++;
    if (mem_addr[1] !== (D_FIRST ? 32'h20 : 32'h200)) begin
      failures++;
      $display("FAIL contest_second_addr got=%h", mem_addr[1]);
    end
    next_cycle();
    if_req = 1'b0; d_req = 1'b0; mem_rdata = 32'h3333_4444;
    @(negedge clk);
    checks++;
    if ({if_rvalid[1], d_rvalid[1], mem_en[1]} !== (D_FIRST ? 3'b100 : 3'b010)) begin
      failures++;
      $display("FAIL contest_second_rvalid got=%b", {if_rvalid[1], d_rvalid[1], mem_en[1]});
    end
    checks++;
    if ((D_FIRST ? if_rdata[1] : d_rdata[1]) !== 32'h3333_4444) begin
      failures++;
      $display("FAIL contest_second_rdata got=%h exp=33334444", D_FIRST ? if_rdata[1] : d_rdata[1]);
    end
  endtask

  task automatic test_store();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({d_gnt[1], mem_en[1], mem_we[1], mem_wmask[1]} !== 7'b111_0011) begin
      failures++;
      $display("FAIL store_ctrl got=%b exp=1110011", {d_gnt[1], mem_en[1], mem_we[1], mem_wmask[1]});
    end
    checks++;
    if ({mem_addr[1], mem_wdata[1]} !== {32'h40, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL store_payload got=%h exp=00000040deadbeef", {mem_addr[1], mem_wdata[1]});
    end
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid[1], if_rvalid[1], d_rdata[1]} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL store_ack got=%b/%h exp=10/00000000", {d_rvalid[1], if_rvalid[1]}, d_rdata[1]);
    end
    checks++;
    if ({mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1], mem_wmask[1]} !== 70'h0) begin
      failures++;
      $display("FAIL store_idle_bus got=%h exp=0",
               {mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1], mem_wmask[1]});
    end
  endtask

  task automatic test_latency3();
    do_reset();
    if_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if_addr   = 32'h100 + 32'(4 * (i / 3));
      mem_rdata = 32'hA5A5_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if ({if_gnt[3], mem_en[3]} !== {2{(i % 3) == 0}}) begin
        failures++;
        $display("FAIL lat3_gnt cycle=%0d got=%b", i, {if_gnt[3], mem_en[3]});
      end
      checks++;
      if (if_rvalid[3] !== (i >= 3 && (i % 3) == 0)) begin
        failures++;
        $display("FAIL lat3_rvalid cycle=%0d got=%b", i, if_rvalid[3]);
      end
      if ((i % 3) == 0) begin
        checks++;
        if (mem_addr[3] !== 32'h100 + 32'(4 * (i / 3))) begin
          failures++;
          $display("FAIL lat3_addr cycle=%0d got=%h", i, mem_addr[3]);
        end
      end
      if (i >= 3 && (i % 3) == 0) begin
        checks++;
        if (if_rdata[3] !== 32'hA5A5_0000 + 32'(i)) begin
          failures++;
          $display("FAIL lat3_rdata cycle=%0d got=%h", i, if_rdata[3]);
        end
      end
      next_cycle();
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if (d_gnt[2] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_gnt got=%b exp=1", d_gnt[2]);
    end
    next_cycle();
    d_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt[2], d_gnt[2], if_rvalid[2], d_rvalid[2], mem_en[2], d_rdata[2]} !== 37'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=0",
               {if_gnt[2], d_gnt[2], if_rvalid[2], d_rvalid[2], mem_en[2], d_rdata[2]});
    end
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({d_rvalid[2], if_rvalid[2]} !== 2'b00) begin
        failures++;
        $display("FAIL rstmid_no_rvalid cycle=%0d got=%b exp=00", i, {d_rvalid[2], if_rvalid[2]});
      end
      next_cycle();
    end
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    checks++;
    if ({if_gnt[2], mem_addr[2]} !== {1'b1, 32'h44}) begin
      failures++;
      $display("FAIL rstmid_reissue got=%b/%h exp=1/00000044", if_gnt[2], mem_addr[2]);
    end
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_early_rvalid got=%b exp=0", if_rvalid[2]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({if_rvalid[2], if_rdata[2]} !== {1'b1, 32'h0BAD_CAFE}) begin
      failures++;
      $display("FAIL rstmid_reissue_rdata got=%b/%h exp=1/0badcafe", if_rvalid[2], if_rdata[2]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    if_req = 1'b1; if_addr = 32'h600;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt[1], d_gnt[1]} !== ((RR && (i % 2) == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL b2b_grant cycle=%0d got=%b exp=%b", i, {if_gnt[1], d_gnt[1]},
                 (RR && (i % 2) == 0) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch();
    test_contest();
    test_store();
    test_latency3();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hart_mem_arbiter
`default_nettype wire
